fifo_sync_param: RTL and testbench

// - Parametrised single-clock FIFO buffer; next generation of the team's 8x32 FIFO.
// - Adds configurable width/depth, true simultaneous read+write, almost-full/empty thresholds,

---
 rtl/fifo_sync_param.sv | 103 ++++++++++
 tb/tb_fifo_sync_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with almost-full/empty flags, occupancy and error pulses.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through output; the default is registered read.
module fifo_sync_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     EN,
    input  logic                     WR,
    input  logic [WIDTH-1:0]         dataIn,
    input  logic                     RD,
    output logic [WIDTH-1:0]         dataOut,
    output logic                     VALID,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     ALMOST_EMPTY,
    output logic                     ALMOST_FULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    output logic                     UNDERFLOW
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;
    logic          overflow_reg, underflow_reg;
    logic          wr_ok, rd_ok;

    assign EMPTY        = (count_reg == '0);
    assign FULL         = (count_reg == DEPTH_C);
    assign ALMOST_EMPTY = (count_reg <= AE_C);
    assign ALMOST_FULL  = (count_reg >= AF_C);
    assign COUNT        = count_reg;
    assign OVERFLOW     = overflow_reg;
    assign UNDERFLOW    = underflow_reg;

    // A full FIFO still takes a write when the same cycle pops a word.
    always_comb begin
        wr_ok      = EN & WR & (~FULL | RD);
        rd_ok      = EN & RD & ~EMPTY;
        count_next = count_reg;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst && wr_ok)
            mem[wr_ptr_reg] <= dataIn;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (EN) begin
            if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg     <= count_next;
            overflow_reg  <= WR & ~wr_ok;
            underflow_reg <= RD & ~rd_ok;
        end else begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    // Head word is presented directly; RD only acknowledges it.
    assign dataOut = mem[rd_ptr_reg];
    assign VALID   = ~EMPTY;
`else
    logic [WIDTH-1:0] data_out_reg;
    logic             valid_reg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
        end else if (EN) begin
            valid_reg <= rd_ok;
            if (rd_ok) data_out_reg <= mem[rd_ptr_reg];
        end
    end

    assign dataOut = data_out_reg;
    assign VALID   = valid_reg;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param (WIDTH=32, DEPTH=8, AF=6, AE=2).
module tb_fifo_sync_param;
    logic        Clk = 1'b0;
    logic        Rst, EN, WR, RD;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        VALID, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW;
    logic [3:0]  COUNT;

    int n_vec = 0;
    int n_err = 0;

    fifo_sync_param #(.WIDTH(32), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut (
        .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .dataIn(dataIn), .RD(RD),
        .dataOut(dataOut), .VALID(VALID), .EMPTY(EMPTY), .FULL(FULL),
        .ALMOST_EMPTY(ALMOST_EMPTY), .ALMOST_FULL(ALMOST_FULL), .COUNT(COUNT),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Rst = 1'b1; EN = 1'b0; WR = 1'b0; RD = 1'b0; dataIn = '0;
        tick;
        Rst = 1'b0; EN = 1'b1;
        n_vec++; if (COUNT !== 4'd0)       begin n_err++; $display("FAIL reset_count: got %0d expected 0", COUNT); end
        n_vec++; if (EMPTY !== 1'b1)       begin n_err++; $display("FAIL reset_empty: got %b expected 1", EMPTY); end
        n_vec++; if (ALMOST_EMPTY !== 1'b1) begin n_err++; $display("FAIL reset_aempty: got %b expected 1", ALMOST_EMPTY); end
        n_vec++; if (FULL !== 1'b0)        begin n_err++; $display("FAIL reset_full: got %b expected 0", FULL); end
        n_vec++; if (ALMOST_FULL !== 1'b0) begin n_err++; $display("FAIL reset_afull: got %b expected 0", ALMOST_FULL); end
        n_vec++; if (VALID !== 1'b0)       begin n_err++; $display("FAIL reset_valid: got %b expected 0", VALID); end
        n_vec++; if ({OVERFLOW, UNDERFLOW} !== 2'b00) begin n_err++; $display("FAIL reset_err: got %b%b expected 00", OVERFLOW, UNDERFLOW); end
`ifndef FIFO_SYNC_FWFT_EN
        n_vec++; if (dataOut !== 32'h0)    begin n_err++; $display("FAIL reset_data: got %h expected 0", dataOut); end
`endif
        $display("reset: COUNT=%0d EMPTY=%b VALID=%b", COUNT, EMPTY, VALID);
    endtask

`ifdef FIFO_SYNC_FWFT_EN
    task automatic test_fwft;
        WR = 1'b1; dataIn = 32'h5A;
        tick;
        WR = 1'b0;
        n_vec++; if (VALID !== 1'b1)      begin n_err++; $display("FAIL fwft_valid: got %b expected 1", VALID); end
        n_vec++; if (dataOut !== 32'h5A)  begin n_err++; $display("FAIL fwft_data: got %h expected 5a", dataOut); end
        tick;
        n_vec++; if (dataOut !== 32'h5A)  begin n_err++; $display("FAIL fwft_hold: got %h expected 5a", dataOut); end
        n_vec++; if (COUNT !== 4'd1)      begin n_err++; $display("FAIL fwft_count: got %0d expected 1", COUNT); end
        RD = 1'b1;
        tick;
        RD = 1'b0;
        n_vec++; if (EMPTY !== 1'b1)      begin n_err++; $display("FAIL fwft_empty: got %b expected 1", EMPTY); end
        n_vec++; if (VALID !== 1'b0)      begin n_err++; $display("FAIL fwft_valid_pop: got %b expected 0", VALID); end
        n_vec++; if (UNDERFLOW !== 1'b0)  begin n_err++; $display("FAIL fwft_unf: got %b expected 0", UNDERFLOW); end
        $display("fwft: head 0x5A shown without RD, popped, EMPTY=%b", EMPTY);
    endtask
`else
    task automatic test_fill;
        WR = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dataIn = 32'h11 * (i + 1);
            tick;
            n_vec++; if (COUNT !== 4'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, COUNT, i + 1); end
            n_vec++; if (ALMOST_FULL !== (i + 1 >= 6)) begin n_err++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, ALMOST_FULL, (i + 1 >= 6)); end
            n_vec++; if (FULL !== (i + 1 == 8)) begin n_err++; $display("FAIL fill_full[%0d]: got %b expected %b", i, FULL, (i + 1 == 8)); end
            n_vec++; if (ALMOST_EMPTY !== (i + 1 <= 2)) begin n_err++; $display("FAIL fill_aempty[%0d]: got %b expected %b", i, ALMOST_EMPTY, (i + 1 <= 2)); end
            $display("fill: wrote %h COUNT=%0d", dataIn, COUNT);
        end
        dataIn = 32'hDEAD_BEEF;
        tick;
        n_vec++; if (OVERFLOW !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %b expected 1", OVERFLOW); end
        n_vec++; if (COUNT !== 4'd8)    begin n_err++; $display("FAIL ovf_count: got %0d expected 8", COUNT); end
        $display("overflow: OVERFLOW=%b COUNT=%0d", OVERFLOW, COUNT);
        EN = 1'b0;
        tick;
        EN = 1'b1; WR = 1'b0;
        n_vec++; if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL ovf_clear_en0: got %b expected 0", OVERFLOW); end
        $display("en0 after overflow: OVERFLOW=%b", OVERFLOW);
    endtask

    task automatic test_drain;
        RD = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            n_vec++; if (dataOut !== 32'h11 * (i + 1)) begin n_err++; $display("FAIL drain_data[%0d]: got %h expected %h", i, dataOut, 32'h11 * (i + 1)); end
            n_vec++; if (VALID !== 1'b1)      begin n_err++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, VALID); end
            n_vec++; if (COUNT !== 4'(7 - i)) begin n_err++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, COUNT, 7 - i); end
            $display("drain: read %h COUNT=%0d", dataOut, COUNT);
        end
        RD = 1'b0;
        tick;
        n_vec++; if (EMPTY !== 1'b1)       begin n_err++; $display("FAIL drain_empty: got %b expected 1", EMPTY); end
        n_vec++; if (VALID !== 1'b0)       begin n_err++; $display("FAIL drain_valid_idle: got %b expected 0", VALID); end
        n_vec++; if (dataOut !== 32'h88)   begin n_err++; $display("FAIL drain_hold: got %h expected 88", dataOut); end
        $display("drain done: EMPTY=%b dataOut=%h", EMPTY, dataOut);
    endtask

    task automatic test_underflow;
        RD = 1'b1; WR = 1'b0;
        tick;
        n_vec++; if (UNDERFLOW !== 1'b1) begin n_err++; $display("FAIL unf_pulse: got %b expected 1", UNDERFLOW); end
        n_vec++; if (VALID !== 1'b0)     begin n_err++; $display("FAIL unf_valid: got %b expected 0", VALID); end
        n_vec++; if (COUNT !== 4'd0)     begin n_err++; $display("FAIL unf_count: got %0d expected 0", COUNT); end
        $display("underflow: UNDERFLOW=%b COUNT=%0d", UNDERFLOW, COUNT);
        WR = 1'b1; dataIn = 32'hAA;
        tick;
        n_vec++; if (COUNT !== 4'd1)     begin n_err++; $display("FAIL rdwr_empty_count: got %0d expected 1", COUNT); end
        n_vec++; if (UNDERFLOW !== 1'b1) begin n_err++; $display("FAIL rdwr_empty_unf: got %b expected 1", UNDERFLOW); end
        $display("rd+wr on empty: COUNT=%0d UNDERFLOW=%b", COUNT, UNDERFLOW);
        WR = 1'b0;
        tick;
        RD = 1'b0;
        n_vec++; if (dataOut !== 32'hAA) begin n_err++; $display("FAIL rdwr_empty_data: got %h expected aa", dataOut); end
        n_vec++; if (UNDERFLOW !== 1'b0) begin n_err++; $display("FAIL unf_clear: got %b expected 0", UNDERFLOW); end
        n_vec++; if (COUNT !== 4'd0)     begin n_err++; $display("FAIL rdwr_empty_pop: got %0d expected 0", COUNT); end
        $display("pop: dataOut=%h COUNT=%0d", dataOut, COUNT);
    endtask

    task automatic test_full_rw;
        WR = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dataIn = 32'h101 + i;
            tick;
        end
        RD = 1'b1; dataIn = 32'h99;
        tick;
        WR = 1'b0;
        n_vec++; if (COUNT !== 4'd8)      begin n_err++; $display("FAIL fullrw_count: got %0d expected 8", COUNT); end
        n_vec++; if (dataOut !== 32'h101) begin n_err++; $display("FAIL fullrw_data: got %h expected 101", dataOut); end
        n_vec++; if (OVERFLOW !== 1'b0)   begin n_err++; $display("FAIL fullrw_ovf: got %b expected 0", OVERFLOW); end
        $display("full rd+wr: COUNT=%0d dataOut=%h", COUNT, dataOut);
        for (int k = 0; k < 8; k++) begin
            tick;
            n_vec++; if (dataOut !== ((k < 7) ? 32'h102 + k : 32'h99)) begin n_err++; $display("FAIL fullrw_drain[%0d]: got %h expected %h", k, dataOut, (k < 7) ? 32'h102 + k : 32'h99); end
            $display("full rd+wr drain: read %h", dataOut);
        end
        RD = 1'b0;
        tick;
        n_vec++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL fullrw_empty: got %b expected 1", EMPTY); end
    endtask

    task automatic test_wrap;
        logic [31:0] q[$];
        logic [31:0] expd;
        logic        rd_exp;
        for (int i = 0; i < 20; i++) begin
            WR = ((i % 4) != 3); RD = ((i % 2) == 1); dataIn = 32'hC000 + i;
            rd_exp = RD && (q.size() > 0);
            expd = '0;
            if (rd_exp) expd = q.pop_front();
            if (WR) q.push_back(dataIn);
            tick;
            n_vec++; if (VALID !== rd_exp) begin n_err++; $display("FAIL wrap_valid[%0d]: got %b expected %b", i, VALID, rd_exp); end
            if (rd_exp) begin
                n_vec++; if (dataOut !== expd) begin n_err++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, dataOut, expd); end
            end
            n_vec++; if (COUNT !== 4'(q.size())) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, COUNT, q.size()); end
            $display("wrap op %0d: WR=%b RD=%b dataOut=%h COUNT=%0d", i, WR, RD, dataOut, COUNT);
        end
        WR = 1'b0; RD = 1'b1;
        while (q.size() > 0) begin
            expd = q.pop_front();
            tick;
            n_vec++; if (dataOut !== expd) begin n_err++; $display("FAIL wrap_drain: got %h expected %h", dataOut, expd); end
            $display("wrap drain: read %h", dataOut);
        end
        RD = 1'b0;
        tick;
    endtask

    task automatic test_enable;
        WR = 1'b1; dataIn = 32'h31; tick;
        dataIn = 32'h32; tick;
        WR = 1'b0; RD = 1'b1; tick;
        n_vec++; if (dataOut !== 32'h31) begin n_err++; $display("FAIL en_pre_data: got %h expected 31", dataOut); end
        EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            WR = (i % 2 == 0); RD = (i != 2); dataIn = 32'hE0 + i;
            tick;
            n_vec++; if (COUNT !== 4'd1)      begin n_err++; $display("FAIL en0_count[%0d]: got %0d expected 1", i, COUNT); end
            n_vec++; if (dataOut !== 32'h31)  begin n_err++; $display("FAIL en0_data[%0d]: got %h expected 31", i, dataOut); end
            n_vec++; if ({OVERFLOW, UNDERFLOW} !== 2'b00) begin n_err++; $display("FAIL en0_err[%0d]: got %b%b expected 00", i, OVERFLOW, UNDERFLOW); end
            $display("en0 cycle %0d: COUNT=%0d dataOut=%h", i, COUNT, dataOut);
        end
        EN = 1'b1; WR = 1'b0; RD = 1'b1;
        tick;
        n_vec++; if (dataOut !== 32'h32) begin n_err++; $display("FAIL en_resume_data: got %h expected 32", dataOut); end
        n_vec++; if (COUNT !== 4'd0)     begin n_err++; $display("FAIL en_resume_count: got %0d expected 0", COUNT); end
        $display("resume: dataOut=%h COUNT=%0d", dataOut, COUNT);
        RD = 1'b0; WR = 1'b1; dataIn = 32'h41;
        tick;
        WR = 1'b0; EN = 1'b0; Rst = 1'b1;
        tick;
        Rst = 1'b0; EN = 1'b1;
        n_vec++; if (COUNT !== 4'd0)     begin n_err++; $display("FAIL rst_en0_count: got %0d expected 0", COUNT); end
        n_vec++; if (EMPTY !== 1'b1)     begin n_err++; $display("FAIL rst_en0_empty: got %b expected 1", EMPTY); end
        n_vec++; if (dataOut !== 32'h0)  begin n_err++; $display("FAIL rst_en0_data: got %h expected 0", dataOut); end
        n_vec++; if (VALID !== 1'b0)     begin n_err++; $display("FAIL rst_en0_valid: got %b expected 0", VALID); end
        $display("reset with EN=0: COUNT=%0d dataOut=%h", COUNT, dataOut);
    endtask
`endif

    initial begin
        Rst = 1'b1; EN = 1'b0; WR = 1'b0; RD = 1'b0; dataIn = '0;
        test_reset;
`ifdef FIFO_SYNC_FWFT_EN
        test_fwft;
`else
        test_fill;
        test_drain;
        test_underflow;
        test_full_rw;
        test_wrap;
        test_enable;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
